// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the multi-channel PWM block.
//   pwm_mode_e : counter mode (edge-aligned sawtooth / center-aligned triangle)
//   pwm_dir_e  : counter direction in center mode
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int PWM_W_DEF     = 11;
  localparam int PWM_NCH_DEF   = 2;
  localparam int PWM_BLANK_DEF = 256;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: pending (shadow) duty, active duty and the registered
// compare output.
//   clk, rst_n : clock, async active-low reset
//   duty_in    : requested duty for this channel
//   duty_vld   : strobe loading duty_in into the shadow
//   synch      : last cycle of the period (commit point)
//   pend       : shadow holds an uncommitted value
//   cnt        : shared period counter
//   kill       : force output low (fault latched or fault input high)
//   pwm        : registered PWM output
module pwm_chan #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] duty_in,
  input  logic         duty_vld,
  input  logic         synch,
  input  logic         pend,
  input  logic [W-1:0] cnt,
  input  logic         kill,
  output logic         pwm
);

  logic [W-1:0] pend_duty;
  logic [W-1:0] act_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_duty <= '0;
      act_duty  <= '0;
      pwm       <= 1'b0;
    end else begin
      if (duty_vld && !synch) pend_duty <= duty_in;
      // A strobe in the commit cycle bypasses the shadow and wins over it.
      if (synch) begin
        if (duty_vld)  act_duty <= duty_in;
        else if (pend) act_duty <= pend_duty;
      end
      pwm <= (cnt < act_duty) && !kill;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with edge/center-aligned modes, double-buffered
// duty updates at period end, fault shutdown and over-current blanking.
//   clk, rst_n    : clock, async active-low reset
//   duty          : NCH packed duties, channel i at [i*W +: W]
//   duty_vld      : one-cycle strobe capturing duty
//   center        : requested mode (0 edge, 1 center), taken at period end
//   fault         : active-high fault input
//   PWM_sig       : registered per-channel outputs
//   PWM_synch     : high in the last cycle of each period
//   OVR_I_blank_n : low during the blanking window at period start
//   duty_ack      : pulse when a new duty becomes active
//   faulted       : latched fault status
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int W     = PWM_W_DEF,
  parameter int NCH   = PWM_NCH_DEF,
  parameter int BLANK = PWM_BLANK_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH*W-1:0] duty,
  input  logic           duty_vld,
  input  logic           center,
  input  logic           fault,
  output logic [NCH-1:0] PWM_sig,
  output logic           PWM_synch,
  output logic           OVR_I_blank_n,
  output logic           duty_ack,
  output logic           faulted
);

  localparam logic [W-1:0] MAX     = '1;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] BLANK_C = W'(BLANK);

  logic [W-1:0] cnt, cnt_nxt;
  pwm_dir_e     dir, dir_nxt;
  pwm_mode_e    mode, mode_nxt, req_mode;
  logic         synch, pend, fault_lat, blank_n;

  assign req_mode = center ? PWM_CENTER : PWM_EDGE;
  assign synch = ((mode == PWM_EDGE) && (cnt == MAX)) ||
                 ((mode == PWM_CENTER) && (dir == DIR_DOWN) && (cnt == ONE));

  // Every period ends with the counter restarting at 0 counting up,
  // which is also where a mode switch takes effect.
  always_comb begin
    cnt_nxt  = cnt + ONE;
    dir_nxt  = dir;
    mode_nxt = mode;
    if (synch) begin
      cnt_nxt  = '0;
      dir_nxt  = DIR_UP;
      mode_nxt = req_mode;
    end else if (mode == PWM_CENTER) begin
      if (dir == DIR_DOWN) begin
        cnt_nxt = cnt - ONE;
      end else if (cnt == MAX) begin
        cnt_nxt = MAX - ONE;
        dir_nxt = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dir       <= DIR_UP;
      mode      <= PWM_EDGE;
      pend      <= 1'b0;
      fault_lat <= 1'b0;
      blank_n   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      mode      <= mode_nxt;
      pend      <= synch ? 1'b0 : (duty_vld | pend);
      fault_lat <= fault | (fault_lat & ~synch);
      // Decoded from next state so the window lines up with cnt itself.
      blank_n   <= !((cnt_nxt < BLANK_C) &&
                     ((mode_nxt == PWM_EDGE) || (dir_nxt == DIR_UP)));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_chan #(.W(W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .duty_in  (duty[i*W +: W]),
      .duty_vld (duty_vld),
      .synch    (synch),
      .pend     (pend),
      .cnt      (cnt),
      .kill     (fault_lat | fault),
      .pwm      (PWM_sig[i])
    );
  end

  assign PWM_synch     = synch;
  assign duty_ack      = synch & (pend | duty_vld);
  assign faulted       = fault_lat;
  assign OVR_I_blank_n = blank_n;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi at W=4, NCH=2, BLANK=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] duty = '0;
  logic       duty_vld = 1'b0;
  logic       center = 1'b0;
  logic       fault = 1'b0;
  logic [1:0] PWM_sig;
  logic       PWM_synch;
  logic       OVR_I_blank_n;
  logic       duty_ack;
  logic       faulted;

  int errors = 0;
  int checks = 0;
  int acks;
  logic [31:0] p0, p1, bl, sy;

  pwm_multi #(.W(4), .NCH(2), .BLANK(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .duty          (duty),
    .duty_vld      (duty_vld),
    .center        (center),
    .fault         (fault),
    .PWM_sig       (PWM_sig),
    .PWM_synch     (PWM_synch),
    .OVR_I_blank_n (OVR_I_blank_n),
    .duty_ack      (duty_ack),
    .faulted       (faulted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_duty(input logic [3:0] d0, input logic [3:0] d1);
    duty     = {d1, d0};
    duty_vld = 1'b1;
    tick();
    duty_vld = 1'b0;
  endtask

  // Sample i is taken one tick later than the period position i; PWM_sig
  // bit i therefore reflects the counter value at position i.
  task automatic period(input int n, output logic [31:0] a0, output logic [31:0] a1,
                        output logic [31:0] ab, output logic [31:0] as);
    a0 = '0; a1 = '0; ab = '0; as = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      a0[i] = PWM_sig[0];
      a1[i] = PWM_sig[1];
      ab[i] = OVR_I_blank_n;
      as[i] = PWM_synch;
    end
  endtask

  initial begin
    tick(3);
    chk("rst_pwm", {30'd0, PWM_sig}, 32'd0);
    chk("rst_blank", {31'd0, OVR_I_blank_n}, 32'd0);
    rst_n = 1'b1;
    // cnt = 0
    chk("rel_pwm", {30'd0, PWM_sig}, 32'd0);
    chk("rel_blank", {31'd0, OVR_I_blank_n}, 32'd0);
    chk("rel_faulted", {31'd0, faulted}, 32'd0);
    chk("rel_ack", {31'd0, duty_ack}, 32'd0);
    chk("rel_synch", {31'd0, PWM_synch}, 32'd0);

    // Shadow load mid-period, commit at cnt 15
    tick(4);
    set_duty(4'd5, 4'd0);                         // cnt 5
    chk("t1_noack", {31'd0, duty_ack}, 32'd0);
    tick(10);                                     // cnt 15
    chk("t1_synch", {31'd0, PWM_synch}, 32'd1);
    chk("t1_ack", {31'd0, duty_ack}, 32'd1);
    tick();                                       // cnt 0
    chk("t1_ack_off", {31'd0, duty_ack}, 32'd0);
    period(16, p0, p1, bl, sy);
    chk("t1_ch0", p0, 32'h0000_001F);
    chk("t1_ch1", p1, 32'h0000_0000);
    chk("t1_blank", bl, 32'h0000_7FFC);
    chk("t1_synch_pat", sy, 32'h0000_4000);

    // Two strobes in one period: last wins, one ack
    tick(2);
    set_duty(4'd3, 4'd0);                         // cnt 3
    tick(3);
    set_duty(4'd9, 4'd2);                         // cnt 7
    acks = int'(duty_ack);
    for (int i = 0; i < 8; i++) begin
      tick();
      acks += int'(duty_ack);
    end                                           // cnt 15
    chk("t2_ack_at_synch", {31'd0, duty_ack}, 32'd1);
    chk("t2_ack_count", acks, 32'd1);
    tick();
    period(16, p0, p1, bl, sy);
    chk("t2_ch0", p0, 32'h0000_01FF);
    chk("t2_ch1", p1, 32'h0000_0003);

    // Strobe coincident with synch goes straight to active
    tick(15);                                     // cnt 15
    duty     = {4'd15, 4'd1};
    duty_vld = 1'b1;
    #1;
    chk("t3_ack_coinc", {31'd0, duty_ack}, 32'd1);
    tick();
    duty_vld = 1'b0;
    #1;
    chk("t3_ack_off", {31'd0, duty_ack}, 32'd0);
    period(16, p0, p1, bl, sy);
    chk("t3_ch0", p0, 32'h0000_0001);
    chk("t3_ch1", p1, 32'h0000_7FFF);
    chk("t3_blank", bl, 32'h0000_7FFC);

    // Center mode requested mid-period, switch at next synch
    tick(3);
    set_duty(4'd5, 4'd15);                        // cnt 4
    center = 1'b1;
    tick(11);                                     // cnt 15, still edge
    chk("t4_synch_edge", {31'd0, PWM_synch}, 32'd1);
    chk("t4_ack", {31'd0, duty_ack}, 32'd1);
    tick();                                       // center j=0
    chk("t4_nosynch", {31'd0, PWM_synch}, 32'd0);
    period(30, p0, p1, bl, sy);
    chk("t4_ch0", p0, 32'h3C00_001F);
    chk("t4_ch1", p1, 32'h3FFF_7FFF);
    chk("t4_blank", bl, 32'h1FFF_FFFC);
    chk("t4_synch_pat", sy, 32'h1000_0000);

    // Back to edge, then a one-cycle fault
    center = 1'b0;
    set_duty(4'd12, 4'd4);                        // j=1
    tick(28);                                     // j=29
    chk("t5_synch_center", {31'd0, PWM_synch}, 32'd1);
    chk("t5_ack", {31'd0, duty_ack}, 32'd1);
    tick(8);                                      // edge cnt 7
    chk("t5_pre_pwm", {30'd0, PWM_sig}, 32'd1);
    fault = 1'b1;
    #1;
    chk("t5_pre_faulted", {31'd0, faulted}, 32'd0);
    tick();                                       // cnt 8
    fault = 1'b0;
    chk("t5_pwm_off", {30'd0, PWM_sig}, 32'd0);
    chk("t5_faulted", {31'd0, faulted}, 32'd1);
    tick();                                       // cnt 9
    chk("t5_pwm_held", {30'd0, PWM_sig}, 32'd0);
    tick(6);                                      // cnt 15
    chk("t5_faulted_synch", {31'd0, faulted}, 32'd1);
    chk("t5_synch", {31'd0, PWM_synch}, 32'd1);
    tick();                                       // cnt 0
    chk("t5_cleared", {31'd0, faulted}, 32'd0);
    tick();                                       // cnt 1
    chk("t5_resume", {30'd0, PWM_sig}, 32'd3);

    // Async reset mid-period with a pending duty
    set_duty(4'd7, 4'd7);                         // cnt 2
    tick(8);                                      // cnt 10
    chk("t6_pre_pwm", {30'd0, PWM_sig}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm", {30'd0, PWM_sig}, 32'd0);
    chk("t6_rst_blank", {31'd0, OVR_I_blank_n}, 32'd0);
    chk("t6_rst_synch", {31'd0, PWM_synch}, 32'd0);
    chk("t6_rst_ack", {31'd0, duty_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;                                 // cnt 0
    tick(15);                                     // cnt 15
    chk("t6_synch", {31'd0, PWM_synch}, 32'd1);
    chk("t6_noack", {31'd0, duty_ack}, 32'd0);
    tick();
    period(16, p0, p1, bl, sy);
    chk("t6_ch0", p0, 32'h0000_0000);
    chk("t6_ch1", p1, 32'h0000_0000);
    chk("t6_blank", bl, 32'h0000_7FFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter W, default 11, counter and duty width in bits.
REQ-002 Parameter NCH, default 2, number of PWM channels.
REQ-003 Parameter BLANK, default 256, over-current blanking length in counter states (1 <= BLANK < 2^W-1).
REQ-004 clk  in  1  system clock (50 MHz); single clock domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 duty  in  NCH*W  requested duty; channel i at bits [i*W +: W].
REQ-007 duty_vld  in  1  one-cycle strobe capturing duty into the pending shadow.
REQ-008 center  in  1  mode request: 0 = edge-aligned, 1 = center-aligned.
REQ-009 fault  in  1  over-current/fault input; active-high.
REQ-010 PWM_sig  out  NCH  registered per-channel PWM outputs to the H-bridges.
REQ-011 PWM_synch  out  1  one-cycle pulse in the last cycle of each period.
REQ-012 OVR_I_blank_n  out  1  low during blanking window at period start.
REQ-013 duty_ack  out  1  one-cycle pulse when pending duty is committed to active.
REQ-014 faulted  out  1  latched fault status.

Function
REQ-015 Counter cnt, W bits, MAX = 2^W-1; edge mode: 0,1,...,MAX, wrap to 0 (period 2^W).
REQ-016 Center mode: up 0..MAX, then down MAX-1..1, then 0 (period 2*MAX); direction flag dir (up/down).
REQ-017 PWM_synch = 1 when (edge and cnt==MAX) or (center and dir==down and cnt==1); combinational from registered state.
REQ-018 Active mode changes only in the PWM_synch cycle (center sampled then); on switch, next cycle starts cnt=0, dir=up.
REQ-019 duty_vld=1 loads pending shadow and sets pend flag; later duty_vld overwrites pending (last wins).
REQ-020 In PWM_synch cycle with pend set: active duty <= pending, pend cleared, duty_ack=1 that cycle.
REQ-021 duty_vld coincident with PWM_synch: incoming duty goes directly to active, pend cleared, duty_ack=1.
REQ-022 Active duty never changes mid-period.
REQ-023 PWM_sig[i] <= (cnt < active_duty[i]) and not fault_lat and not fault; one-cycle latency from cnt.
REQ-024 duty=0 gives constant low; duty=MAX gives high for all but cnt==MAX (edge) / all but cnt==MAX (center).
REQ-025 fault=1 sets fault_lat next cycle; PWM_sig forced low the cycle after fault asserts (same edge as latch).
REQ-026 fault_lat cleared only in a PWM_synch cycle with fault=0; outputs resume at next period start.
REQ-027 faulted = fault_lat; counter, shadow and duty_ack continue running while faulted.
REQ-028 OVR_I_blank_n registered: low while (edge and cnt < BLANK) or (center and dir==up and cnt < BLANK), else high.

Reset
REQ-029 rst_n low: cnt=0, dir=up, mode=edge, active and pending duty=0, pend=0, fault_lat=0.
REQ-030 Reset outputs: PWM_sig=0, OVR_I_blank_n=0, faulted=0, duty_ack=0; PWM_synch=0 (cnt=0).
REQ-031 Reset mid-period aborts period immediately; pending duty discarded.

Structure
REQ-032 Package pwm_pkg holds mode enum (PWM_EDGE, PWM_CENTER), direction enum, default W/NCH/BLANK constants.
REQ-033 Sub-module pwm_chan (per-channel pending/active duty and compare/output flop), instantiated NCH times by generate; counter, mode, fault and blanking logic in pwm_multi.

Verification (W=4, NCH=2, BLANK=3 unless noted)
REQ-034 Reset release, duty_vld with ch0=5, ch1=0 mid-period -> no change until synch; duty_ack at cnt==15; next period ch0 high 5 of 16 cycles, ch1 constant low.
REQ-035 duty_vld twice (ch0=3 then 9) in one period -> single duty_ack, ch0 high 9 cycles next period.
REQ-036 center=1 set mid-period -> switch at next synch; period 30 cycles, synch at dir=down cnt=1; ch0=5 high for 9 cycles (cnt 0..4 up, 4..1 down).
REQ-037 fault pulse 1 cycle at cnt=7 with ch0=12 -> PWM_sig[0] low from next cycle, faulted high, clears at synch, ch0 resumes at cnt=0 next period.
REQ-038 OVR_I_blank_n low for cnt 0..2 every edge period; duty_vld coincident with synch -> duty_ack same cycle, new duty in next period.
REQ-039 rst_n asserted at cnt=10 with pending duty -> all outputs reset asynchronously; after release, active duty 0, no duty_ack.
